shared_dff_arbiter: RTL

SHARED_DFF_ARBITER -- requirements
Module: shared_dff_arbiter

---
 rtl/shared_dff_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/shared_dff_arbiter.sv
// shared_dff_arbiter
//   Two requesters share one WIDTH-bit register. In IDLE, a single request
//   is granted directly. If both requesters ask at once, the one that did
//   not win last time is granted (round-robin). A grant loads Q with the
//   winner's data and pulses that requester's gnt for one cycle. It then
//   starts a lock-out window of HOLD cycles, during which requests are
//   ignored. All state updates happen on the falling edge of clock.
//
// Ports
//   clock        : single clock, falling-edge active
//   reset        : asynchronous, active-high
//   req0, req1   : write requests
//   data0, data1 : write data for each requester
//   gnt0, gnt1   : one-cycle grant/ack pulses
//   Q, NQ        : shared register and its bitwise complement
//   busy         : high while the lock-out window is active
//
// state  | meaning
// S_IDLE | accepting requests, arbitrating on each falling edge
// S_HOLD | lock-out after a grant; cnt counts down to the return edge
module shared_dff_arbiter #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             last_win, last_win_nxt;  // 1 = requester 1 won last
  logic [WIDTH-1:0] q_nxt;
  logic             gnt0_nxt, gnt1_nxt;
  logic             pick0;

  // Requester 0 wins when it is alone, or on a tie when 1 won last.
  assign pick0 = req0 & (~req1 | last_win);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_win_nxt = last_win;
    q_nxt        = Q;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 | req1) begin
          if (pick0) begin
            gnt0_nxt     = 1'b1;
            q_nxt        = data0;
            last_win_nxt = 1'b0;
          end else begin
            gnt1_nxt     = 1'b1;
            q_nxt        = data1;
            last_win_nxt = 1'b1;
          end
          // With no lock-out configured, stay in IDLE and arbitrate every edge.
          if (HOLD_CNT != 4'd0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_CNT;
          end
        end
      end
      S_HOLD: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      last_win <= 1'b1;
      Q        <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_win <= last_win_nxt;
      Q        <= q_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
    end
  end

  assign NQ   = ~Q;
  assign busy = (state == S_HOLD);

endmodule
